// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to the renderer and connector.
// The master drives every signal; the slave only observes.
interface vga_sync_gen_if;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       line_tick;
  logic       frame_tick;

  modport master (
    output hCount, vCount, bright, hSync, vSync, line_tick, frame_tick
  );

  modport slave (
    input hCount, vCount, bright, hSync, vSync, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster generator: pixel divider, h/v counters, and registered
// sync, blanking and line/frame strobes that stay aligned with the counters.
module vga_sync_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515
) (
  input  logic           clk,
  input  logic           Reset,
  vga_sync_gen_if.master vga
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW   = 10'(H_SYNC);
  localparam logic [9:0] V_SW   = 10'(V_SYNC);
  localparam logic [9:0] H_AS   = 10'(H_ACT_START);
  localparam logic [9:0] H_AE   = 10'(H_ACT_END);
  localparam logic [9:0] V_AS   = 10'(V_ACT_START);
  localparam logic [9:0] V_AE   = 10'(V_ACT_END);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt, v_cnt;
  logic [9:0]       h_next, v_next;
  logic             pix_en, h_wrap, v_wrap;
  logic             hsync_q, vsync_q, bright_q, line_q, frame_q;

  assign pix_en = (div == DIV_LAST);
  assign h_wrap = pix_en && (h_cnt == H_LAST);
  assign v_wrap = h_wrap && (v_cnt == V_LAST);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (pix_en) h_next = h_wrap ? '0 : h_cnt + 10'd1;
    if (h_wrap) v_next = v_wrap ? '0 : v_cnt + 10'd1;
  end

  // Decoded outputs are registered from the next counter values, so they always
  // describe the position being presented in the same cycle.
  // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      div      <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      div      <= pix_en ? '0 : div + DIV_ONE;
      h_cnt    <= h_next;
      v_cnt    <= v_next;
      hsync_q  <= (h_next >= H_SW);
      vsync_q  <= (v_next >= V_SW);
      bright_q <= (h_next >= H_AS) && (h_next < H_AE) &&
                  (v_next >= V_AS) && (v_next < V_AE);
      line_q   <= h_wrap;
      frame_q  <= v_wrap;
    end
  end

  assign vga.hCount     = h_cnt;
  assign vga.vCount     = v_cnt;
  assign vga.hSync      = hsync_q;
  assign vga.vSync      = vsync_q;
  assign vga.bright     = bright_q;
  assign vga.line_tick  = line_q;
  assign vga.frame_tick = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: expected raster samples are queued by cycle-after-reset and
// popped by per-instance monitors; a small raster instance covers frame behaviour.
module tb_vga_sync_gen;

  typedef struct {
    int         cyc;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs, vs, br, lt, ft;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic seg1_a;
  int   cyc_a, cyc_b;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$], qb[$], qc[$];

  int lt_a = 0, ft_a = 0, hs_low_a = 0, hs_high_a = 0, br_a = 0;
  int lt_b = 0, ft_b = 0, br_b = 0, vs_low_b = 0, br_c = 0;

  always #5 clk = ~clk;

  // a: full default timing; b: CLK_DIV=1 with a small raster; c: default
  // horizontal timing with a short frame so the visible line is reachable.
  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();
  vga_sync_gen_if ifc ();

  vga_sync_gen dut_a (.clk(clk), .Reset(rst_a), .vga(ifa));

  vga_sync_gen #(
    .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(4), .V_ACT_END(10)
  ) dut_b (.clk(clk), .Reset(rst_b), .vga(ifb));

  vga_sync_gen #(
    .V_TOTAL(4), .V_SYNC(1), .V_ACT_START(1), .V_ACT_END(3)
  ) dut_c (.clk(clk), .Reset(rst_b), .vga(ifc));

  always @(posedge clk or posedge rst_a)
    if (rst_a) cyc_a <= 0;
    else       cyc_a <= cyc_a + 1;

  always @(posedge clk or posedge rst_b)
    if (rst_b) cyc_b <= 0;
    else       cyc_b <= cyc_b + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cmp(input string dn, input exp_t e, input logic [9:0] h, input logic [9:0] v,
                     input logic hs, input logic vs, input logic br, input logic lt, input logic ft);
    checks++;
    if (h !== e.h || v !== e.v || hs !== e.hs || vs !== e.vs ||
        br !== e.br || lt !== e.lt || ft !== e.ft) begin
      errors++;
      $display("FAIL %s_k%0d: got h=%0d v=%0d hs=%b vs=%b br=%b lt=%b ft=%b expected h=%0d v=%0d hs=%b vs=%b br=%b lt=%b ft=%b",
               dn, e.cyc, h, v, hs, vs, br, lt, ft, e.h, e.v, e.hs, e.vs, e.br, e.lt, e.ft);
    end
  endtask

  task automatic push(input int d, input int k, input int h, input int v,
                      input bit hs, input bit vs, input bit br, input bit lt, input bit ft);
    exp_t e;
    e.cyc = k; e.h = 10'(h); e.v = 10'(v);
    e.hs = hs; e.vs = vs; e.br = br; e.lt = lt; e.ft = ft;
    case (d)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // Monitors: the cycle count is the number of rising edges since reset release.
  always @(negedge clk) begin
    if (!rst_a) begin
      if (qa.size() > 0 && qa[0].cyc == cyc_a)
        cmp("a", qa.pop_front(), ifa.hCount, ifa.vCount, ifa.hSync, ifa.vSync,
            ifa.bright, ifa.line_tick, ifa.frame_tick);
      if (ifa.line_tick)  lt_a <= lt_a + 1;
      if (ifa.frame_tick) ft_a <= ft_a + 1;
      if (seg1_a && cyc_a < 3200) begin
        if (!ifa.hSync) hs_low_a  <= hs_low_a + 1;
        else            hs_high_a <= hs_high_a + 1;
        if (ifa.bright) br_a <= br_a + 1;
      end
    end
    if (!rst_b) begin
      if (qb.size() > 0 && qb[0].cyc == cyc_b)
        cmp("b", qb.pop_front(), ifb.hCount, ifb.vCount, ifb.hSync, ifb.vSync,
            ifb.bright, ifb.line_tick, ifb.frame_tick);
      if (qc.size() > 0 && qc[0].cyc == cyc_b)
        cmp("c", qc.pop_front(), ifc.hCount, ifc.vCount, ifc.hSync, ifc.vSync,
            ifc.bright, ifc.line_tick, ifc.frame_tick);
      if (cyc_b < 240) begin
        if (ifb.bright) br_b     <= br_b + 1;
        if (!ifb.vSync) vs_low_b <= vs_low_b + 1;
      end
      if (cyc_b >= 1 && cyc_b <= 240) begin
        if (ifb.line_tick)  lt_b <= lt_b + 1;
        if (ifb.frame_tick) ft_b <= ft_b + 1;
      end
      if (cyc_b >= 3200 && cyc_b < 6400 && ifc.bright) br_c <= br_c + 1;
    end
  end

  initial begin
    bit found;
    rst_a = 1'b1;
    rst_b = 1'b1;
    seg1_a = 1'b1;

    // Default timing, first lines after release (k, h, v, hs, vs, br, lt, ft).
    push(0, 0,    0,   0, 0, 0, 0, 0, 0);
    push(0, 3,    0,   0, 0, 0, 0, 0, 0);
    push(0, 4,    1,   0, 0, 0, 0, 0, 0);
    push(0, 383,  95,  0, 0, 0, 0, 0, 0);
    push(0, 384,  96,  0, 1, 0, 0, 0, 0);
    push(0, 3199, 799, 0, 1, 0, 0, 0, 0);
    push(0, 3200, 0,   1, 0, 0, 0, 1, 0);
    push(0, 3201, 0,   1, 0, 0, 0, 0, 0);
    push(0, 6400, 0,   2, 0, 1, 0, 1, 0);
    push(0, 6403, 0,   2, 0, 1, 0, 0, 0);
    push(0, 6404, 1,   2, 0, 1, 0, 0, 0);
    push(0, 8402, 500, 2, 1, 1, 0, 0, 0);

    // Small raster, one pixel per clock: boundaries and the frame wrap.
    push(1, 0,   0,  0,  0, 0, 0, 0, 0);
    push(1, 1,   1,  0,  0, 0, 0, 0, 0);
    push(1, 3,   3,  0,  1, 0, 0, 0, 0);
    push(1, 19,  19, 0,  1, 0, 0, 0, 0);
    push(1, 20,  0,  1,  0, 0, 0, 1, 0);
    push(1, 40,  0,  2,  0, 1, 0, 1, 0);
    push(1, 65,  5,  3,  1, 1, 0, 0, 0);
    push(1, 84,  4,  4,  1, 1, 0, 0, 0);
    push(1, 85,  5,  4,  1, 1, 1, 0, 0);
    push(1, 196, 16, 9,  1, 1, 1, 0, 0);
    push(1, 197, 17, 9,  1, 1, 0, 0, 0);
    push(1, 205, 5,  10, 1, 1, 0, 0, 0);
    push(1, 239, 19, 11, 1, 1, 0, 0, 0);
    push(1, 240, 0,  0,  0, 0, 0, 1, 1);
    push(1, 241, 1,  0,  0, 0, 0, 0, 0);

    // Default horizontal timing on visible lines.
    push(2, 3200, 0,   1, 0, 1, 0, 1, 0);
    push(2, 3775, 143, 1, 1, 1, 0, 0, 0);
    push(2, 3776, 144, 1, 1, 1, 1, 0, 0);
    push(2, 6335, 783, 1, 1, 1, 1, 0, 0);
    push(2, 6336, 784, 1, 1, 1, 0, 0, 0);
    push(2, 6400, 0,   2, 0, 1, 0, 1, 0);
    push(2, 6976, 144, 2, 1, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("held_reset_a", int'({7'd0, ifa.hCount, ifa.vCount, ifa.hSync, ifa.vSync,
                                ifa.bright, ifa.line_tick, ifa.frame_tick}), 0);
    check("held_reset_b", int'({7'd0, ifb.hCount, ifb.vCount, ifb.hSync, ifb.vSync,
                                ifb.bright, ifb.line_tick, ifb.frame_tick}), 0);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (cyc_a == 8402) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_mid_line_a", int'(found), 1);

    // Asynchronous reset mid-line, well away from any clock edge.
    #1;
    rst_a = 1'b1;
    seg1_a = 1'b0;
    #1;
    check("async_reset_a", int'({7'd0, ifa.hCount, ifa.vCount, ifa.hSync, ifa.vSync,
                                 ifa.bright, ifa.line_tick, ifa.frame_tick}), 0);

    push(0, 0,    0,   0, 0, 0, 0, 0, 0);
    push(0, 4,    1,   0, 0, 0, 0, 0, 0);
    push(0, 3199, 799, 0, 1, 0, 0, 0, 0);
    push(0, 3200, 0,   1, 0, 0, 0, 1, 0);
    push(0, 3201, 0,   1, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    rst_a = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cyc_a == 3204) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_end_a", int'(found), 1);
    #1;

    check("hsync_low_clks_a",  hs_low_a, 384);
    check("hsync_high_clks_a", hs_high_a, 2816);
    check("bright_vblank_a",   br_a, 0);
    check("line_ticks_a",      lt_a, 3);
    check("frame_ticks_a",     ft_a, 0);
    check("bright_clks_b",     br_b, 72);
    check("vsync_low_clks_b",  vs_low_b, 40);
    check("line_ticks_b",      lt_b, 12);
    check("frame_ticks_b",     ft_b, 1);
    check("bright_line_c",     br_c, 2560);
    check("drained_a", qa.size(), 0);
    check("drained_b", qb.size(), 0);
    check("drained_c", qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
